// File: rtl/mem_fetch_pkg.sv
// rtl/mem_fetch_pkg.sv - shared state encoding and default sizes for mem_fetch
package mem_fetch_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush and simultaneous push/pop when full
module fetch_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             last
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign count = wr_ptr_q - rd_ptr_q;
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign last  = (count == ONE_CNT);

   // Head reads as zero when empty so outputs are clean after reset/flush.
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      do_pop   = pop && !empty && !flush;
      do_push  = push && (!full || do_pop) && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/mem_fetch.sv
// rtl/mem_fetch.sv - sequential memory prefetcher with redirect and buffered handshake output
// Define MEM_FETCH_WRAP_EN to wrap PC past the top address instead of draining to DONE.
module mem_fetch
   import mem_fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] PC_MAX = {ADDR_W{1'b1}};

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                flush;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic                last;
   logic [ADDR_W+DATA_W-1:0] head;

   fetch_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .push    (push),
      .pop     (pop),
      .wr_data ({pc_q, mem_data}),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .last    (last)
   );

   assign mem_addr  = pc_q;
   assign out_valid = !empty;
   assign out_addr  = head[ADDR_W+DATA_W-1:DATA_W];
   assign out_data  = head[DATA_W-1:0];
   assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush   = 1'b0;
      push    = 1'b0;
      pop     = out_valid && out_ready;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
               flush   = 1'b1;
            end
         end
         ST_FETCH: begin
            // Redirect wins over any pop: the buffered words are stale.
            if (jump_en) begin
               flush = 1'b1;
               pop   = 1'b0;
               pc_d  = jump_addr;
            end else if (!full || pop) begin
               push = 1'b1;
               if (pc_q == PC_MAX) begin
`ifdef MEM_FETCH_WRAP_EN
                  pc_d = '0;
`else
                  state_d = ST_DRAIN;
`endif
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (jump_en) begin
               flush   = 1'b1;
               pop     = 1'b0;
               pc_d    = jump_addr;
               state_d = ST_FETCH;
            end else if (pop && last) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: tb/tb_mem_fetch.sv
// tb/tb_mem_fetch.sv - randomized and directed bench for mem_fetch against a queue-based model
module tb_mem_fetch;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 2;
   localparam int AMAX   = (1 << ADDR_W) - 1;
`ifdef MEM_FETCH_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              jump_en = 1'b0;
   logic [ADDR_W-1:0] jump_addr = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              busy;
   logic              done;

   int n_tests = 0;
   int n_fail  = 0;

   int m_mode = M_IDLE;
   int m_pc   = 0;
   int m_q[$];

   int xfer_cnt  = 0;
   int prev_addr = -1;
   bit seen_wrap = 1'b0;

   always #5 clk = ~clk;

   assign mem_data = mem_addr[0] ? 8'hAA : 8'hCC;

   mem_fetch #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .jump_en   (jump_en),
      .jump_addr (jump_addr),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   function automatic int img(input int addr);
      return (addr % 2 == 1) ? 32'hAA : 32'hCC;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit pop_v;
      int sz;
      if (rst) begin
         m_q.delete();
         m_pc   = 0;
         m_mode = M_IDLE;
      end else begin
         sz    = m_q.size();
         pop_v = (sz > 0) && out_ready;
         case (m_mode)
            M_IDLE, M_DONE: begin
               if (start) begin
                  m_mode = M_FETCH;
                  m_pc   = 0;
                  m_q.delete();
               end
            end
            M_FETCH: begin
               if (jump_en) begin
                  m_q.delete();
                  m_pc = int'(jump_addr);
               end else begin
                  if (pop_v) void'(m_q.pop_front());
                  if (sz < DEPTH || pop_v) begin
                     m_q.push_back(m_pc);
                     if (m_pc == AMAX) begin
                        if (WRAP) m_pc = 0;
                        else m_mode = M_DRAIN;
                     end else begin
                        m_pc = m_pc + 1;
                     end
                  end
               end
            end
            default: begin
               if (jump_en) begin
                  m_q.delete();
                  m_pc   = int'(jump_addr);
                  m_mode = M_FETCH;
               end else if (pop_v) begin
                  void'(m_q.pop_front());
                  if (m_q.size() == 0) m_mode = M_DONE;
               end
            end
         endcase
      end
   endtask

   task automatic compare_all();
      check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      check("busy", 32'(busy), 32'(m_mode == M_FETCH || m_mode == M_DRAIN));
      check("done", 32'(done), 32'(m_mode == M_DONE));
      check("mem_addr", 32'(mem_addr), 32'(m_pc));
      if (m_q.size() > 0) begin
         check("out_addr", 32'(out_addr), 32'(m_q[0]));
         check("out_data", 32'(out_data), 32'(img(m_q[0])));
      end
   endtask

   // Called at a negedge with inputs already set; returns at the next negedge.
   task automatic cycle();
      if (out_valid && out_ready && !rst && !jump_en) begin
         xfer_cnt++;
         if (prev_addr == AMAX && out_addr == '0) seen_wrap = 1'b1;
         prev_addr = int'(out_addr);
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      jump_en = 1'b0;
      cycle();
      rst = 1'b0;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_addr", 32'(out_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pc", 32'(mem_addr), 32'd0);
   endtask

   initial begin
      int guard;
      bit hit;
      @(negedge clk);
      do_reset();

`ifndef MEM_FETCH_WRAP_EN
      // Test 1: full sequential sweep with downstream always ready
      out_ready = 1'b1;
      xfer_cnt  = 0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("t1_no_valid_at_start", 32'(out_valid), 32'd0);
      cycle();
      check("t1_first_valid", 32'(out_valid), 32'd1);
      check("t1_first_addr", 32'(out_addr), 32'd0);
      repeat (20) cycle();
      check("t1_xfers", 32'(xfer_cnt), 32'd16);
      check("t1_done", 32'(done), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);
`else
      // Test 5: wrap build keeps fetching past the top address
      out_ready = 1'b1;
      xfer_cnt  = 0;
      seen_wrap = 1'b0;
      prev_addr = -1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (20) cycle();
      check("t5_seen_wrap", 32'(seen_wrap), 32'd1);
      check("t5_done", 32'(done), 32'd0);
      check("t5_busy", 32'(busy), 32'd1);
      do_reset();
`endif

      // Test 2: stalled downstream fills the buffer and holds PC
      out_ready = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (5) cycle();
      check("t2_pc_held", 32'(mem_addr), 32'd2);
      check("t2_head_addr", 32'(out_addr), 32'd0);
      check("t2_head_data", 32'(out_data), 32'hCC);
      out_ready = 1'b1;
      cycle();
      check("t2_resume_addr", 32'(out_addr), 32'd1);
      check("t2_resume_data", 32'(out_data), 32'hAA);

      // Test 3: redirect at PC=4 while out_ready toggles
      guard = 0;
      while (m_pc != 4 && guard < 30) begin
         out_ready = ~out_ready;
         cycle();
         guard++;
      end
      check("t3_reach_pc4", 32'(m_pc), 32'd4);
      jump_en   = 1'b1;
      jump_addr = 4'd9;
      cycle();
      jump_en = 1'b0;
      check("t3_flushed", 32'(out_valid), 32'd0);
      check("t3_pc9", 32'(mem_addr), 32'd9);
      hit = 1'b0;
      guard = 0;
      while (!hit && guard < 10) begin
         out_ready = ~out_ready;
         cycle();
         if (out_valid) begin
            hit = 1'b1;
            check("t3_next_addr", 32'(out_addr), 32'd9);
            check("t3_next_data", 32'(out_data), 32'hAA);
         end
         guard++;
      end
      check("t3_next_seen", 32'(hit), 32'd1);
      repeat (24) begin
         out_ready = ~out_ready;
         cycle();
      end
`ifndef MEM_FETCH_WRAP_EN
      check("t3_done", 32'(done), 32'd1);

      // Test 4: reset in the middle of DRAIN
      do_reset();
      out_ready = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      guard = 0;
      while (m_mode != M_DRAIN && guard < 40) begin
         cycle();
         guard++;
      end
      check("t4_in_drain", 32'(busy && m_mode == M_DRAIN), 32'd1);
`else
      // Test 4 (wrap build): reset in the middle of FETCH
      repeat (3) cycle();
`endif
      do_reset();
      xfer_cnt = 0;
      out_ready = 1'b1;
      jump_en   = 1'b1;
      jump_addr = 4'd3;
      repeat (5) cycle();
      jump_en = 1'b0;
      check("t4_no_xfers", 32'(xfer_cnt), 32'd0);
      check("t4_idle", 32'(busy), 32'd0);

      // Random phase
      for (int i = 0; i < 600; i++) begin
         out_ready = ($urandom % 4) != 0;
         start     = ($urandom % 12) == 0;
         jump_en   = ($urandom % 18) == 0;
         jump_addr = ADDR_W'($urandom);
         rst       = ($urandom % 150) == 0;
         cycle();
      end
      rst = 1'b0;
      start = 1'b0;
      jump_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_fetch.md
MEM_FETCH -- requirements
Module: mem_fetch

Interface
REQ-001: Parameter ADDR_W, default 4, SHALL set the memory address width.
REQ-002: Parameter DATA_W, default 8, SHALL set the memory data width.
REQ-003: Parameter DEPTH, default 2, SHALL set the number of prefetch buffer entries (power of two, >=2).
REQ-004: The block SHALL use one clock; reset is synchronous and active-high.
REQ-005: clk  in  1  rising-edge clock.
REQ-006: rst  in  1  synchronous active-high reset.
REQ-007: start  in  1  one-cycle pulse that begins sequential fetch from address 0.
REQ-008: jump_en  in  1  redirect pulse.
REQ-009: jump_addr  in  ADDR_W  redirect target.
REQ-010: mem_addr  out  ADDR_W  address to the combinational memory (equals PC).
REQ-011: mem_data  in  DATA_W  memory read data, valid in the same cycle as mem_addr.
REQ-012: out_data  out  DATA_W  buffered data word.
REQ-013: out_addr  out  ADDR_W  address the out_data word was read from.
REQ-014: out_valid / out_ready  out / in  1 / 1  downstream handshake; transfer when both are high on a clock edge.
REQ-015: busy  out  1  high in FETCH or DRAIN.
REQ-016: done  out  1  high in DONE.

Function
REQ-017: The FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
REQ-018: IDLE->FETCH on start, with PC set to 0 and the buffer empty.
REQ-019: In FETCH, a push of {PC, mem_data} SHALL occur when the buffer is not full or a pop occurs in the same cycle; PC SHALL then increment by 1.
REQ-020: Without wrap, the push of address 2^ADDR_W-1 SHALL move the FSM FETCH->DRAIN, and PC SHALL hold.
REQ-021: DRAIN->DONE when the buffer becomes empty (last pop).
REQ-022: DONE->FETCH on start (PC=0).
REQ-023: start SHALL be ignored in FETCH and DRAIN.
REQ-024: jump_en in FETCH or DRAIN SHALL flush the buffer, load PC with jump_addr and enter FETCH; there is no push and no pop that cycle.
REQ-025: jump_en takes priority over a simultaneous pop.
REQ-026: jump_en in IDLE or DONE SHALL be ignored.
REQ-027: out_valid SHALL be high exactly when the buffer is non-empty.
REQ-028: out_data and out_addr SHALL come from the buffer head and be stable while out_valid=1 and out_ready=0.
REQ-029: Latency: with start sampled at edge N, the first push SHALL occur at edge N+1 and out_valid SHALL be high after edge N+1. With out_ready held high, throughput is one word per cycle.
REQ-030: Words SHALL be delivered in push order with no loss or duplication.
REQ-031: A pop with out_ready=1 while the buffer is empty SHALL have no effect.

Reset
REQ-032: rst SHALL force, at the clock edge: state=IDLE, PC=0, buffer empty, out_valid=0, out_data=0, out_addr=0, busy=0, done=0.
REQ-033: rst SHALL override start and jump_en, including mid-FETCH and mid-DRAIN.

Configuration
REQ-034: Macro MEM_FETCH_WRAP_EN defined: PC SHALL wrap from 2^ADDR_W-1 to 0 and remain in FETCH; DRAIN and DONE are never entered and done stays 0.
REQ-035: Macro MEM_FETCH_WRAP_EN undefined: behaviour SHALL be as in REQ-020 and REQ-021.

Structure
REQ-036: Package mem_fetch_pkg SHALL hold the FSM state enum and the default ADDR_W, DATA_W and DEPTH constants.
REQ-037: The buffer SHALL be a sub-module fetch_fifo (synchronous FIFO with push, pop, full and empty); the FSM and PC stay in mem_fetch.

Verification (memory image: 0xCC at even addresses, 0xAA at odd addresses)
REQ-038: Test 1: rst, then start with out_ready=1. The bench SHALL see 16 transfers (addr 0..15, data CC,AA,...), the first visible one cycle after start is sampled, then done=1 and busy=0.
REQ-039: Test 2: start with out_ready=0 for 5 cycles. The bench SHALL see the buffer full after 2 pushes, PC=2 held, out_addr=0 and out_data=0xCC stable; releasing out_ready resumes with addr 1 (0xAA).
REQ-040: Test 3: jump_en with jump_addr=9 at the cycle PC=4, while out_ready toggles. The bench SHALL see the buffer flushed and the next transfer addr 9, data 0xAA, continuing to 15.
REQ-041: Test 4: rst asserted mid-DRAIN. The bench SHALL see all outputs at reset values next cycle and no further transfers until start.
REQ-042: Test 5: with MEM_FETCH_WRAP_EN defined and out_ready=1 for 20 cycles, the transfer after addr 15 SHALL be addr 0 (0xCC) and done SHALL stay 0.
